// File: rtl/vga_pkg.sv
// Shared VGA geometry presets, sync polarity constants and axis helpers.
// Imported by the axis counter and the timing generator top level.
package vga_pkg;

   localparam int SYNC_ACTIVE_LOW  = 0;
   localparam int SYNC_ACTIVE_HIGH = 1;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FRONT  = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BACK   = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FRONT  = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BACK   = 33;

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FRONT  = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BACK   = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FRONT  = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BACK   = 23;

   function automatic int axis_total(input int active, input int front,
                                     input int sync, input int back);
      return active + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-tick input and raster timing outputs of the VGA timing generator.
// master = timing generator, slave = display pipeline consumer.
interface vga_timing_gen_if #(
   parameter int POS_W = 10
);
   logic             enable;
   logic             hSync;
   logic             vSync;
   logic [POS_W-1:0] hPos;
   logic [POS_W-1:0] vPos;
   logic             active;
   logic             lineStart;
   logic             frameStart;
   logic             lineFetch;

   modport master (
      input  enable,
      output hSync, vSync, hPos, vPos, active, lineStart, frameStart, lineFetch
   );

   modport slave (
      output enable,
      input  hSync, vSync, hPos, vPos, active, lineStart, frameStart, lineFetch
   );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with exact terminal-value wrap and registered sync.
// pos_next/in_active expose next-state values so the top can register zero-skew outputs.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FRONT  = 16,
   parameter int SYNC   = 96,
   parameter int BACK   = 48,
   parameter int POL    = SYNC_ACTIVE_LOW,
   parameter int W      = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         advance,
   output logic [W-1:0] pos,
   output logic [W-1:0] pos_next,
   output logic         wrap,
   output logic         in_active,
   output logic         sync
);

   localparam int         TOTAL      = axis_total(ACTIVE, FRONT, SYNC, BACK);
   localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FRONT);
   localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FRONT + SYNC);
   localparam logic         ASSERTED   = (POL != 0);

   logic sync_next;

   always_comb begin
      wrap      = advance && (pos == LAST);
      pos_next  = pos;
      if (wrap)
         pos_next = '0;
      else if (advance)
         pos_next = pos + W'(1);
      in_active = (pos_next < ACT_END);
      sync_next = ((pos_next >= SYNC_START) && (pos_next < SYNC_END)) ? ASSERTED : ~ASSERTED;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos  <= '0;
         sync <= ~ASSERTED;
      end else if (advance) begin
         pos  <= pos_next;
         sync <= sync_next;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, blanking, coordinates and event strobes.
// Every output is registered from next-state counter values, so all outputs describe the same pixel.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = VGA640_H_ACTIVE,
   parameter int H_FRONT    = VGA640_H_FRONT,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BACK     = VGA640_H_BACK,
   parameter int V_ACTIVE   = VGA640_V_ACTIVE,
   parameter int V_FRONT    = VGA640_V_FRONT,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BACK     = VGA640_V_BACK,
   parameter int H_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int V_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter int FETCH_LEAD = 32,
   parameter int POS_W      = 10
) (
   input  logic      clk,
   input  logic      reset,
   vga_timing_gen_if.master bus
);

   localparam int             H_TOTAL   = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int             V_TOTAL   = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
   localparam logic [POS_W-1:0] V_LAST    = POS_W'(V_TOTAL - 1);
   localparam logic [POS_W-1:0] V_ACT_END = POS_W'(V_ACTIVE);
   localparam logic [POS_W-1:0] FETCH_POS = POS_W'(H_TOTAL - FETCH_LEAD);

   logic [POS_W-1:0] h_pos, h_pos_next, v_pos, v_pos_next, v_following;
   logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
   logic             v_advance, next_line_visible;
   logic             active, line_start, frame_start, line_fetch;

   assign v_advance = bus.enable & h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE), .FRONT (H_FRONT), .SYNC (H_SYNC), .BACK (H_BACK),
      .POL    (H_SYNC_POL), .W (POS_W)
   ) u_h_axis (
      .clk       (clk),
      .reset     (reset),
      .advance   (bus.enable),
      .pos       (h_pos),
      .pos_next  (h_pos_next),
      .wrap      (h_wrap),
      .in_active (h_act),
      .sync      (h_sync)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE), .FRONT (V_FRONT), .SYNC (V_SYNC), .BACK (V_BACK),
      .POL    (V_SYNC_POL), .W (POS_W)
   ) u_v_axis (
      .clk       (clk),
      .reset     (reset),
      .advance   (v_advance),
      .pos       (v_pos),
      .pos_next  (v_pos_next),
      .wrap      (v_wrap),
      .in_active (v_act),
      .sync      (v_sync)
   );

   // The fetch point is never at hPos 0, so v_pos_next is the line the fetch belongs to.
   always_comb begin
      v_following       = (v_pos_next == V_LAST) ? '0 : v_pos_next + POS_W'(1);
      next_line_visible = (v_following < V_ACT_END);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active      <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         line_fetch  <= 1'b0;
      end else begin
         line_start  <= h_wrap;
         frame_start <= h_wrap & v_wrap;
         line_fetch  <= bus.enable && (h_pos_next == FETCH_POS) && next_line_visible;
         if (bus.enable)
            active <= h_act & v_act;
      end
   end

   assign bus.hPos       = h_pos;
   assign bus.vPos       = v_pos;
   assign bus.hSync      = h_sync;
   assign bus.vSync      = v_sync;
   assign bus.active     = active;
   assign bus.lineStart  = line_start;
   assign bus.frameStart = frame_start;
   assign bus.lineFetch  = line_fetch;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three geometries (640x480, a tiny raster, 800x600 high-polarity)
// compared every clock against a pixel-index reference model.
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs, vs, act, ls, fs, lf;
   } obs_t;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, fl;
   } geom_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vga_timing_gen_if #(.POS_W(10)) bus_def ();
   vga_timing_gen_if #(.POS_W(6))  bus_sm ();
   vga_timing_gen_if #(.POS_W(11)) bus_svga ();

   vga_timing_gen u_def (.clk(clk), .reset(reset), .bus(bus_def.master));

   vga_timing_gen #(
      .H_ACTIVE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
      .V_ACTIVE(10), .V_FRONT(2), .V_SYNC(3), .V_BACK(4),
      .H_SYNC_POL(0), .V_SYNC_POL(1), .FETCH_LEAD(6), .POS_W(6)
   ) u_sm (.clk(clk), .reset(reset), .bus(bus_sm.master));

   vga_timing_gen #(
      .H_ACTIVE(SVGA800_H_ACTIVE), .H_FRONT(SVGA800_H_FRONT),
      .H_SYNC(SVGA800_H_SYNC), .H_BACK(SVGA800_H_BACK),
      .V_ACTIVE(SVGA800_V_ACTIVE), .V_FRONT(SVGA800_V_FRONT),
      .V_SYNC(SVGA800_V_SYNC), .V_BACK(SVGA800_V_BACK),
      .H_SYNC_POL(1), .V_SYNC_POL(1), .FETCH_LEAD(40), .POS_W(11)
   ) u_svga (.clk(clk), .reset(reset), .bus(bus_svga.master));

   geom_t  g_def, g_sm, g_svga;
   longint idx_def, idx_sm, idx_svga;
   bit     en_def, en_sm, en_svga;
   int     checks = 0;
   int     passed = 0;

   // Expected outputs after idx enabled ticks since reset; en = this clock carried a tick.
   function automatic obs_t model(input geom_t g, input longint idx, input bit en);
      obs_t o;
      int ht = g.ha + g.hf + g.hs + g.hb;
      int vt = g.va + g.vf + g.vs + g.vb;
      int h  = int'(idx % longint'(ht));
      int v  = int'((idx / longint'(ht)) % longint'(vt));
      int nv = (v + 1) % vt;
      o.h   = 11'(h);
      o.v   = 11'(v);
      o.hs  = (h >= g.ha + g.hf && h < g.ha + g.hf + g.hs) ? (g.hp != 0) : (g.hp == 0);
      o.vs  = (v >= g.va + g.vf && v < g.va + g.vf + g.vs) ? (g.vp != 0) : (g.vp == 0);
      o.act = (h < g.ha) && (v < g.va);
      o.ls  = en && (h == 0);
      o.fs  = en && (h == 0) && (v == 0);
      o.lf  = en && (h == ht - g.fl) && (nv < g.va);
      return o;
   endfunction

   function automatic obs_t obs_def();
      return {11'(bus_def.hPos), 11'(bus_def.vPos), bus_def.hSync, bus_def.vSync,
              bus_def.active, bus_def.lineStart, bus_def.frameStart, bus_def.lineFetch};
   endfunction

   function automatic obs_t obs_sm();
      return {11'(bus_sm.hPos), 11'(bus_sm.vPos), bus_sm.hSync, bus_sm.vSync,
              bus_sm.active, bus_sm.lineStart, bus_sm.frameStart, bus_sm.lineFetch};
   endfunction

   function automatic obs_t obs_svga();
      return {11'(bus_svga.hPos), 11'(bus_svga.vPos), bus_svga.hSync, bus_svga.vSync,
              bus_svga.active, bus_svga.lineStart, bus_svga.frameStart, bus_svga.lineFetch};
   endfunction

   // Drives enables, advances one clock and samples 1 ns after the edge; no checking here.
   task automatic tick(input bit e0, input bit e1, input bit e2);
      bus_def.enable  = e0;
      bus_sm.enable   = e1;
      bus_svga.enable = e2;
      @(posedge clk);
      #1;
      en_def = e0; en_sm = e1; en_svga = e2;
      if (e0) idx_def++;
      if (e1) idx_sm++;
      if (e2) idx_svga++;
   endtask

   task automatic clear_model();
      idx_def = 0; idx_sm = 0; idx_svga = 0;
      en_def = 0; en_sm = 0; en_svga = 0;
   endtask

   task automatic test_reset();
      obs_t e;
      reset = 1'b0;
      bus_def.enable = 1'b0; bus_sm.enable = 1'b0; bus_svga.enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      clear_model();
      e = model(g_def, idx_def, 1'b0);
      checks++;
      if (obs_def() !== e) $display("FAIL reset_def actual=%h required=%h", obs_def(), e);
      else passed++;
      e = model(g_sm, idx_sm, 1'b0);
      checks++;
      if (obs_sm() !== e) $display("FAIL reset_sm actual=%h required=%h", obs_sm(), e);
      else passed++;
      e = model(g_svga, idx_svga, 1'b0);
      checks++;
      if (obs_svga() !== e) $display("FAIL reset_svga actual=%h required=%h", obs_svga(), e);
      else passed++;
      checks++;
      if (bus_svga.hSync !== 1'b0 || bus_def.hSync !== 1'b1 || bus_def.active !== 1'b1)
         $display("FAIL reset_levels actual hs_def=%b hs_svga=%b act=%b required 1 0 1",
                  bus_def.hSync, bus_svga.hSync, bus_def.active);
      else passed++;
      reset = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      e = model(g_def, idx_def, en_def);
      checks++;
      if (obs_def() !== e) $display("FAIL reset_release actual=%h required=%h", obs_def(), e);
      else passed++;
   endtask

   task automatic test_default_lines();
      obs_t e;
      int lo_cnt = 0;
      int lo_first = -1;
      for (int i = 0; i < 2 * 800 + 100; i++) begin
         tick(1'b1, 1'b0, 1'b0);
         e = model(g_def, idx_def, en_def);
         checks++;
         if (obs_def() !== e)
            $display("FAIL def_line idx=%0d actual=%h required=%h", idx_def, obs_def(), e);
         else passed++;
         if (bus_def.vPos == 10'd0 && bus_def.hSync == 1'b0) begin
            if (lo_cnt == 0) lo_first = int'(bus_def.hPos);
            lo_cnt++;
         end
      end
      checks++;
      if (lo_cnt !== 96 || lo_first !== 656)
         $display("FAIL def_hsync_window actual len=%0d start=%0d required len=96 start=656",
                  lo_cnt, lo_first);
      else passed++;
   endtask

   task automatic test_small_frame();
      obs_t e;
      int fs_seen = 0, fs_cyc0 = 0, fs_cyc1 = 0, lf_cnt = 0;
      for (int c = 0; c < 3 * 608 && fs_seen < 2; c++) begin
         tick(1'b0, 1'b1, 1'b0);
         e = model(g_sm, idx_sm, en_sm);
         checks++;
         if (obs_sm() !== e)
            $display("FAIL sm_frame idx=%0d actual=%h required=%h", idx_sm, obs_sm(), e);
         else passed++;
         if (fs_seen == 1 && bus_sm.lineFetch) lf_cnt++;
         if (bus_sm.frameStart) begin
            if (fs_seen == 0) fs_cyc0 = c; else fs_cyc1 = c;
            fs_seen++;
         end
      end
      checks++;
      if (fs_seen < 2 || fs_cyc1 - fs_cyc0 !== 608 || lf_cnt !== 10)
         $display("FAIL sm_frame_period actual seen=%0d period=%0d fetches=%0d required period=608 fetches=10",
                  fs_seen, fs_cyc1 - fs_cyc0, lf_cnt);
      else passed++;
   endtask

   task automatic test_frame_wrap();
      obs_t e;
      for (int c = 0; c < 700 && (idx_sm % 608) != 607; c++) begin
         tick(1'b0, 1'b1, 1'b0);
         e = model(g_sm, idx_sm, en_sm);
         checks++;
         if (obs_sm() !== e)
            $display("FAIL wrap_approach idx=%0d actual=%h required=%h", idx_sm, obs_sm(), e);
         else passed++;
      end
      checks++;
      if (bus_sm.hPos !== 6'd31 || bus_sm.vPos !== 6'd18)
         $display("FAIL wrap_last actual h=%0d v=%0d required h=31 v=18", bus_sm.hPos, bus_sm.vPos);
      else passed++;
      tick(1'b0, 1'b1, 1'b0);
      checks++;
      if (bus_sm.hPos !== 6'd0 || bus_sm.vPos !== 6'd0 || bus_sm.lineStart !== 1'b1 ||
          bus_sm.frameStart !== 1'b1 || bus_sm.active !== 1'b1)
         $display("FAIL wrap_first actual h=%0d v=%0d ls=%b fs=%b act=%b required 0 0 1 1 1",
                  bus_sm.hPos, bus_sm.vPos, bus_sm.lineStart, bus_sm.frameStart, bus_sm.active);
      else passed++;
   endtask

   task automatic test_enable_div4();
      obs_t e;
      int fs_seen = 0, fs_cyc0 = 0, fs_cyc1 = 0;
      for (int c = 0; c < 2 * 608 * 4 + 8 && fs_seen < 2; c++) begin
         tick(1'b0, (c % 4) == 3, 1'b0);
         e = model(g_sm, idx_sm, en_sm);
         checks++;
         if (obs_sm() !== e)
            $display("FAIL div4 c=%0d actual=%h required=%h", c, obs_sm(), e);
         else passed++;
         if (bus_sm.frameStart) begin
            if (fs_seen == 0) fs_cyc0 = c; else fs_cyc1 = c;
            fs_seen++;
         end
      end
      checks++;
      if (fs_seen < 2 || fs_cyc1 - fs_cyc0 !== 2432)
         $display("FAIL div4_period actual seen=%0d period=%0d required 2432",
                  fs_seen, fs_cyc1 - fs_cyc0);
      else passed++;
   endtask

   task automatic test_svga();
      obs_t e;
      int hi_cnt = 0, hi_first = -1, h_max = 0;
      for (int i = 0; i < 2 * 1056 + 10; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         e = model(g_svga, idx_svga, en_svga);
         checks++;
         if (obs_svga() !== e)
            $display("FAIL svga idx=%0d actual=%h required=%h", idx_svga, obs_svga(), e);
         else passed++;
         if (int'(bus_svga.hPos) > h_max) h_max = int'(bus_svga.hPos);
         if (bus_svga.vPos == 11'd0 && bus_svga.hSync == 1'b1) begin
            if (hi_cnt == 0) hi_first = int'(bus_svga.hPos);
            hi_cnt++;
         end
      end
      checks++;
      if (hi_cnt !== 128 || hi_first !== 840 || h_max !== 1055)
         $display("FAIL svga_hsync actual len=%0d start=%0d hmax=%0d required 128 840 1055",
                  hi_cnt, hi_first, h_max);
      else passed++;
   endtask

   task automatic test_reset_midframe();
      obs_t e;
      for (int c = 0; c < 700 && (idx_sm % 608) != 207; c++) begin
         tick(1'b0, 1'b1, 1'b0);
      end
      checks++;
      if (bus_sm.hPos !== 6'd15 || bus_sm.vPos !== 6'd6)
         $display("FAIL midframe_pos actual h=%0d v=%0d required h=15 v=6", bus_sm.hPos, bus_sm.vPos);
      else passed++;
      #2;
      reset = 1'b0;
      #1;
      clear_model();
      e = model(g_sm, 0, 1'b0);
      checks++;
      if (obs_sm() !== e) $display("FAIL midframe_async actual=%h required=%h", obs_sm(), e);
      else passed++;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, 1'b1, 1'b1);
         e = model(g_sm, idx_sm, en_sm);
         checks++;
         if (obs_sm() !== e)
            $display("FAIL midframe_resume idx=%0d actual=%h required=%h", idx_sm, obs_sm(), e);
         else passed++;
         e = model(g_def, idx_def, en_def);
         checks++;
         if (obs_def() !== e)
            $display("FAIL midframe_resume_def idx=%0d actual=%h required=%h", idx_def, obs_def(), e);
         else passed++;
      end
   endtask

   task automatic test_random();
      obs_t e;
      for (int i = 0; i < 4000; i++) begin
         tick($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
         e = model(g_def, idx_def, en_def);
         checks++;
         if (obs_def() !== e)
            $display("FAIL rand_def idx=%0d actual=%h required=%h", idx_def, obs_def(), e);
         else passed++;
         e = model(g_sm, idx_sm, en_sm);
         checks++;
         if (obs_sm() !== e)
            $display("FAIL rand_sm idx=%0d actual=%h required=%h", idx_sm, obs_sm(), e);
         else passed++;
         e = model(g_svga, idx_svga, en_svga);
         checks++;
         if (obs_svga() !== e)
            $display("FAIL rand_svga idx=%0d actual=%h required=%h", idx_svga, obs_svga(), e);
         else passed++;
      end
   endtask

   initial begin
      g_def  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 32};
      g_sm   = '{20, 3, 4, 5, 10, 2, 3, 4, 0, 1, 6};
      g_svga = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 40};
      reset = 1'b0;
      clear_model();
      test_reset();
      test_default_lines();
      test_small_frame();
      test_frame_wrap();
      test_enable_div4();
      test_svga();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that produces sync, blanking, pixel coordinates and raster event strobes for any resolution and porch/sync geometry. It sits between the pixel-clock enable and the display pipeline (sprite/playfield renderers, colour output stage). It replaces fixed 640x480 timing with generic, zero-skew registered outputs. It also adds a per-line fetch-ahead strobe so renderers can prefetch line data.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BACK, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines per frame
- V_FRONT, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BACK, 33: vertical back porch, lines
- H_SYNC_POL, 0: hSync asserted level (0 = active-low)
- V_SYNC_POL, 0: vSync asserted level
- FETCH_LEAD, 32: pixels before the start of the next visible line at which lineFetch fires; range 1..H_FRONT+H_SYNC+H_BACK
- POS_W, 10: width of hPos/vPos; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  pixel tick; counters advance only on clk edges where enable=1
- hSync  out  1  horizontal sync, polarity per H_SYNC_POL
- vSync  out  1  vertical sync, polarity per V_SYNC_POL
- hPos  out  POS_W  current pixel column, 0..H_TOTAL-1
- vPos  out  POS_W  current line, 0..V_TOTAL-1
- active  out  1  high when hPos<H_ACTIVE and vPos<V_ACTIVE
- lineStart  out  1  one-clk strobe when hPos becomes 0
- frameStart  out  1  one-clk strobe when (hPos,vPos) becomes (0,0)
- lineFetch  out  1  one-clk strobe FETCH_LEAD pixels before the next visible line begins

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Defaults: 800 x 525.
- hPos counts 0..H_TOTAL-1 exactly. On an enable where hPos=H_TOTAL-1, hPos wraps to 0 and vPos advances. vPos wraps from V_TOTAL-1 to 0.
- Sync asserted for hPos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). vSync uses the same rule on vPos with V_* parameters.
- lineFetch condition: hPos = H_TOTAL-FETCH_LEAD and the next line is visible, i.e. (vPos+1) mod V_TOTAL < V_ACTIVE.
- Reset (reset=0, asynchronous): hPos=0, vPos=0, hSync=~H_SYNC_POL, vSync=~V_SYNC_POL, active=1, lineStart=0, frameStart=0, lineFetch=0. Deassertion is synchronous to clk by system convention. The first counted pixel after reset is (0,0), but no start strobe is issued for it.
- Reset mid-frame: immediate return to the reset state. Pending strobes are discarded.
- enable=0: all counters and level outputs hold. Strobes are forced to 0.
- All arithmetic is unsigned, POS_W bits. Wrap compares use == against the terminal value, never overflow.

## Timing
- All outputs are registered. hSync, vSync, active and the strobes are computed from the next-state counter values, so they describe the same hPos/vPos they accompany (zero skew, no one-pixel lag).
- Latency: enable edge N updates all outputs at edge N.
- Strobes are exactly one clk wide, aligned with the clk in which the new position is first presented. They never stretch across a multi-clk pixel.
- At the frame wrap, lineStart and frameStart assert in the same cycle.
- At the last line of the frame with V_ACTIVE>0, lineFetch fires for line 0 of the next frame.

## Structure
- Shared package vga_pkg holds: default 640x480@60 geometry constants, a second preset (800x600), and the sync-polarity constants SYNC_ACTIVE_LOW/HIGH.
- One natural sub-module is vga_axis_counter (parameters ACTIVE, FRONT, SYNC, BACK, POL, W). It has an advance input and outputs pos, wrap, inActive and sync.
- The top level instantiates vga_axis_counter twice. The vertical instance's advance is driven by enable & horizontal wrap. Strobe and lineFetch logic lives in the top level.

## Test plan
- Defaults with enable held high; count clks between frameStart strobes → 420000 (800x525). hSync low for exactly 96 pixels starting at hPos=656. vSync low for lines 490-491 only.
- enable asserted every 4th clk → positions change once per 4 clks; strobes are 1 clk wide; frame period is 1680000 clks.
- hPos=799, vPos=524 then one enable → hPos=0, vPos=0, lineStart=1 and frameStart=1 in the same cycle; active=1.
- FETCH_LEAD=32 → lineFetch at hPos=768 on vPos 0..478 and 524, absent on vPos 479..523. Count per frame → 480.
- Assert reset low at (hPos=300, vPos=200) asynchronously between clk edges → outputs reach reset values before the next edge. After release, counting resumes from (0,0).
- H_SYNC_POL=1 with an 800x600 preset (H_TOTAL=1056, V_TOTAL=628) → hSync high only in the sync window. Wrap at 1055/627 is exact, with no 1056th pixel.
